period_meter: RTL
=================

// Module: period_meter
// PURPOSE
//  Period / high-time meter. Measures the period and high time of an external
//  periodic signal in clk cycles, i.e. the receive-side counterpart of the
//  counter/carry tick generator.
//  Sits between an async input (PPS, encoder, external tick) and a control
//  FSM or AXI-lite register bank. Results leave on a valid/ready handshake.
// PARAMETERS
//  CNT_WIDTH    16  width of the period/high-time counters and results
//  SYNC_STAGES  2   synchronizer flops on sig_in (>=2)
//  EDGE_FALL    0   0: measure rising-to-rising; 1: falling-to-falling
// PORTS
//  clk         in   1          system clock
//  rst         in   1          synchronous, active-high reset
//  en          in   1          measurement enable; 0 forces IDLE
//  sig_in      in   1          asynchronous input signal
//  meas_valid  out  1          result valid
//  meas_ready  in   1          consumer accepts result when valid&ready
//  period      out  CNT_WIDTH  clk cycles between consecutive reference edges
//  high_time   out  CNT_WIDTH  cycles sig was high inside that period
//  ovf         out  1          period saturated (result = all ones)
//  overrun     out  1          sticky: a result was dropped; clears on handshake
//  busy        out  1          state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE. meas_valid, ovf, overrun, busy = 0. period,
//    high_time = 0. Sync chain and counters = 0.
//  - Sync: sig_in passes SYNC_STAGES flops to sig_s, plus one flop sig_d.
//    ref edge = sig_s&~sig_d (EDGE_FALL=0) or ~sig_s&sig_d (EDGE_FALL=1).
//  - FSM: IDLE -(en)-> ARM -(ref edge)-> MEAS. MEAS -(ref edge)-> MEAS with
//    result capture. Any state -(!en)-> IDLE in the same cycle, dropping any
//    partial count. A held result and meas_valid are NOT cleared by !en.
//  - Counters: on each ref edge, pcnt<=1 and hcnt<=sig_s. Otherwise pcnt+=1
//    and hcnt+=sig_s. Both saturate at 2^CNT_WIDTH-1 and never wrap.
//  - Capture at a ref edge in MEAS: period<=pcnt, high_time<=hcnt.
//    ovf<=(pcnt==all ones). meas_valid<=1 the next cycle.
//    Edges at cycles t and t+P give period=P.
//  - Latency: sig_in toggle to meas_valid is SYNC_STAGES+2 clk cycles.
//  - Handshake: the result is stable while meas_valid=1. When valid&ready,
//    meas_valid<=0 and overrun<=0 in the same cycle.
//  - Capture while valid&!ready: the new result is dropped, the old one is
//    held, and overrun<=1.
//    Capture in the same cycle as valid&ready: the new result is loaded,
//    meas_valid stays 1, and overrun<=0.
//  - Edge in the same cycle as the IDLE->ARM entry: ignored. ARM waits for
//    the next edge.
//  - rst mid-measurement: everything returns to reset values next cycle.
//    There is no partial output.
//  - Result high_time<=period always, including the saturated case.
// STRUCTURE
//  - Package is_util_pkg: typedef enum {IDLE,ARM,MEAS} pm_state_t.
//    Localparam for CNT_MAX.
//  - One sub-module: sync_edge_det (SYNC_STAGES flops plus edge detect,
//    outputs sig_s and edge). Counters and FSM live inline.
// TESTING
//  1 en=1, square wave period 10 / high 4, ready=1 -> each result has
//    period=10, high_time=4, ovf=0.
//  2 CNT_WIDTH=4, period 20 -> period=15, high_time<=15, ovf=1.
//  3 ready=0 across 3 edges -> first result held, overrun=1. Raise ready ->
//    valid and overrun drop together.
//  4 en deasserted mid-period, then re-enabled -> busy=0. The first result
//    after re-enable covers a full period only (no stale count).
//  5 rst pulsed one cycle mid-MEAS with a valid result pending ->
//    meas_valid=0, period=0 next cycle.
//  6 EDGE_FALL=1, duty 3/8 -> period=8, high_time=3. Latency from sig_in
//    edge to valid = SYNC_STAGES+2.

Source files
------------

// File: rtl/is_util_pkg.sv
// Shared types and constants for the period meter.
package is_util_pkg;

    typedef enum logic [1:0] {IDLE, ARM, MEAS} pm_state_t;

    localparam int unsigned PM_CNT_WIDTH = 16;
    localparam logic [PM_CNT_WIDTH-1:0] CNT_MAX = '1;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizer for an asynchronous input plus single-edge detection on the
// synchronized signal.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          EDGE_FALL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic sig_s,
    output logic ref_edge
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            sig_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            sig_d  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sig_s    = sync_q[SYNC_STAGES-1];
    assign ref_edge = EDGE_FALL ? (~sig_s & sig_d) : (sig_s & ~sig_d);

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of an external signal in clk cycles and
// presents each result on a valid/ready handshake.
module period_meter
    import is_util_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = PM_CNT_WIDTH,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          EDGE_FALL   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sig_in,
    output logic                 meas_valid,
    input  logic                 meas_ready,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 ovf,
    output logic                 overrun,
    output logic                 busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONES = '1;

    pm_state_t            state;
    logic [CNT_WIDTH-1:0] pcnt;
    logic [CNT_WIDTH-1:0] hcnt;
    logic                 cap_pend;
    logic                 sig_s;
    logic                 ref_edge;
    logic                 capture;
    logic                 take;
    logic                 accept;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES),
        .EDGE_FALL  (EDGE_FALL)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .sig_in  (sig_in),
        .sig_s   (sig_s),
        .ref_edge(ref_edge)
    );

    assign capture = en && (state == MEAS) && ref_edge;
    assign take    = meas_valid && meas_ready;
    // A capture is loaded unless an unconsumed result is still being held.
    assign accept  = capture && (!meas_valid || meas_ready);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pcnt       <= '0;
            hcnt       <= '0;
            period     <= '0;
            high_time  <= '0;
            ovf        <= 1'b0;
            overrun    <= 1'b0;
            meas_valid <= 1'b0;
            cap_pend   <= 1'b0;
        end else begin
            if (!en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE:    state <= ARM;
                    ARM:     if (ref_edge) state <= MEAS;
                    MEAS:    state <= MEAS;
                    default: state <= IDLE;
                endcase
            end

            if (!en || state == IDLE) begin
                pcnt <= '0;
                hcnt <= '0;
            end else if (ref_edge) begin
                pcnt <= CNT_WIDTH'(1);
                hcnt <= CNT_WIDTH'(sig_s);
            end else begin
                if (pcnt != CNT_ONES) pcnt <= pcnt + 1'b1;
                if (sig_s && hcnt != CNT_ONES) hcnt <= hcnt + 1'b1;
            end

            if (accept) begin
                period    <= pcnt;
                high_time <= hcnt;
                ovf       <= (pcnt == CNT_ONES);
            end

            // Fresh results raise valid one cycle after capture; a result loaded
            // during a handshake keeps valid high without a gap.
            cap_pend <= accept && !meas_valid;
            if (cap_pend) begin
                meas_valid <= 1'b1;
            end else if (take && !accept) begin
                meas_valid <= 1'b0;
            end

            if (take) begin
                overrun <= 1'b0;
            end else if (capture && !accept) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
